// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, requests imem, presents PC/instruction to IF/ID.
// Response is passed through combinationally; stall parks it in buf_inst; redirects squash stale responses.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_if,
  output logic [31:0] Instruction_if,
  output logic        valid_if
);

  typedef enum logic [1:0] {REQ, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] buf_inst, buf_nxt;
  logic [31:0] drop_addr, drop_nxt;
  logic [31:0] pc_inc;
  logic [31:0] target;

  assign pc_inc = pc + 32'd4;
  assign target = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= REQ;
      pc        <= RESET_PC;
      buf_inst  <= NOP;
      drop_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      buf_inst  <= buf_nxt;
      drop_addr <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    buf_nxt        = buf_inst;
    drop_nxt       = drop_addr;
    imem_req       = 1'b0;
    imem_addr      = pc;
    valid_if       = 1'b0;
    Instruction_if = NOP;
    PC_if          = pc;

    if (reset) begin
      PC_if     = RESET_PC;
      imem_addr = RESET_PC;
    end else begin
      case (state)
        REQ: begin
          imem_req = 1'b1;
          if (redirect) begin
            pc_nxt = target;
            // Request still in flight: keep driving its address until it returns.
            if (!imem_ready) begin
              state_nxt = DROP;
              drop_nxt  = pc;
            end
          end else if (imem_ready) begin
            valid_if       = 1'b1;
            Instruction_if = imem_rdata;
            if (stall) begin
              buf_nxt   = imem_rdata;
              state_nxt = HOLD;
            end else begin
              pc_nxt = pc_inc;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_nxt    = target;
            state_nxt = REQ;
          end else begin
            valid_if       = 1'b1;
            Instruction_if = buf_inst;
            if (!stall) begin
              pc_nxt    = pc_inc;
              state_nxt = REQ;
            end
          end
        end
        DROP: begin
          imem_req  = 1'b1;
          imem_addr = drop_addr;
          if (redirect) pc_nxt = target;
          if (imem_ready) state_nxt = REQ;
        end
        default: state_nxt = REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: two instances (RESET_PC 0 and FFFF_FFF8), scoreboard on delivered instructions.
module tb_if_fetch_stage;

  localparam logic [31:0] MEMX   = 32'hA5A5_0000;
  localparam logic [31:0] NOPW   = 32'h0000_0013;
  localparam logic [31:0] RPC1   = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        reset_v       [2];
  logic        stall_v       [2];
  logic        redirect_v    [2];
  logic [31:0] redirect_pc_v [2];
  logic        imem_req_v    [2];
  logic [31:0] imem_addr_v   [2];
  logic        imem_ready_v  [2];
  logic [31:0] imem_rdata_v  [2];
  logic [31:0] pc_if_v       [2];
  logic [31:0] inst_v        [2];
  logic        valid_v       [2];

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;

  // Memory model: each word holds its address xor a fixed pattern.
  assign imem_rdata_v[0] = imem_addr_v[0] ^ MEMX;
  assign imem_rdata_v[1] = imem_addr_v[1] ^ MEMX;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP(NOPW)) u_dut0 (
    .clk(clk), .reset(reset_v[0]), .stall(stall_v[0]), .redirect(redirect_v[0]),
    .redirect_pc(redirect_pc_v[0]), .imem_req(imem_req_v[0]), .imem_addr(imem_addr_v[0]),
    .imem_ready(imem_ready_v[0]), .imem_rdata(imem_rdata_v[0]), .PC_if(pc_if_v[0]),
    .Instruction_if(inst_v[0]), .valid_if(valid_v[0])
  );

  if_fetch_stage #(.RESET_PC(RPC1), .NOP(NOPW)) u_dut1 (
    .clk(clk), .reset(reset_v[1]), .stall(stall_v[1]), .redirect(redirect_v[1]),
    .redirect_pc(redirect_pc_v[1]), .imem_req(imem_req_v[1]), .imem_addr(imem_addr_v[1]),
    .imem_ready(imem_ready_v[1]), .imem_rdata(imem_rdata_v[1]), .PC_if(pc_if_v[1]),
    .Instruction_if(inst_v[1]), .valid_if(valid_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = pc ^ MEMX;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Drive one cycle's inputs just after the falling edge; outputs are settled 1 unit later.
  task automatic cyc(input int d, input logic rst, input logic stl, input logic rdr,
                     input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    reset_v[d]       = rst;
    stall_v[d]       = stl;
    redirect_v[d]    = rdr;
    redirect_pc_v[d] = rpc;
    imem_ready_v[d]  = rdy;
    #1;
  endtask

  // Scoreboard monitor: every presented instruction must match the queue head;
  // the head is retired only when the instruction is consumed (stall low).
  initial begin
    exp_t e;
    bit   have;
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        if (valid_v[d]) begin
          have = 1'b0;
          if (d == 0 && q0.size() > 0) begin have = 1'b1; e = q0[0]; end
          if (d == 1 && q1.size() > 0) begin have = 1'b1; e = q1[0]; end
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL sb_unexpected dut%0d: valid_if with PC_if=%08h, none expected", d, pc_if_v[d]);
          end else begin
            chk($sformatf("sb_pc dut%0d", d), pc_if_v[d], e.pc);
            chk($sformatf("sb_inst dut%0d", d), inst_v[d], e.inst);
            if (!stall_v[d]) begin
              if (d == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_v[d] = 1'b1; stall_v[d] = 1'b0; redirect_v[d] = 1'b0;
      redirect_pc_v[d] = 32'h0; imem_ready_v[d] = 1'b0;
    end

    // Reset state
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    chk("rst_req", {31'b0, imem_req_v[0]}, 0);
    chk("rst_valid", {31'b0, valid_v[0]}, 0);
    chk("rst_inst", inst_v[0], NOPW);
    chk("rst_pc", pc_if_v[0], 32'h0);

    // Zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      push(0, 32'(i * 4));
      cyc(0, 0, 0, 0, 0, 1);
      chk("zw_addr", imem_addr_v[0], 32'(i * 4));
      chk("zw_req", {31'b0, imem_req_v[0]}, 1);
    end

    // Ready every third cycle, starting at pc=16
    for (int g = 0; g < 2; g++) begin
      for (int c = 0; c < 3; c++) begin
        if (c == 2) push(0, 32'(16 + g * 4));
        cyc(0, 0, 0, 0, 0, c == 2);
        chk("slow_addr", imem_addr_v[0], 32'(16 + g * 4));
        if (c != 2) chk("slow_valid", {31'b0, valid_v[0]}, 0);
      end
    end

    // Stall: response at pc=24 parked for 3 held cycles, consumed on the 4th
    push(0, 32'd24);
    cyc(0, 0, 1, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      cyc(0, 0, 1, 0, 0, 0);
      chk("hold_req", {31'b0, imem_req_v[0]}, 0);
      chk("hold_pc", pc_if_v[0], 32'd24);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("hold_consume_valid", {31'b0, valid_v[0]}, 1);
    push(0, 32'd28);
    cyc(0, 0, 0, 0, 0, 1);
    chk("after_hold_addr", imem_addr_v[0], 32'd28);

    // Redirect with request outstanding at pc=32, target 0x103 -> 0x100
    cyc(0, 0, 0, 1, 32'h0000_0103, 0);
    chk("rdr_out_addr", imem_addr_v[0], 32'd32);
    chk("rdr_out_valid", {31'b0, valid_v[0]}, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drop_addr", imem_addr_v[0], 32'd32);
    chk("drop_req", {31'b0, imem_req_v[0]}, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("drop_stale_valid", {31'b0, valid_v[0]}, 0);
    chk("drop_stale_inst", inst_v[0], NOPW);
    push(0, 32'h100);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rdr_target_addr", imem_addr_v[0], 32'h100);

    // Second redirect arriving together with the stale response in DROP
    cyc(0, 0, 0, 1, 32'h200, 0);
    cyc(0, 0, 0, 1, 32'h301, 1);
    chk("drop_rdr_addr", imem_addr_v[0], 32'h104);
    chk("drop_rdr_valid", {31'b0, valid_v[0]}, 0);

    // Redirect in HOLD
    push(0, 32'h300);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drop_rdr_next_addr", imem_addr_v[0], 32'h300);
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h40, 0);
    chk("hold_rdr_valid", {31'b0, valid_v[0]}, 0);
    chk("hold_rdr_inst", inst_v[0], NOPW);
    q0.delete();

    // Redirect together with stall and ready in REQ
    cyc(0, 0, 1, 1, 32'h80, 1);
    chk("hold_rdr_next_addr", imem_addr_v[0], 32'h40);
    chk("rdr_stall_valid", {31'b0, valid_v[0]}, 0);
    chk("rdr_stall_inst", inst_v[0], NOPW);
    push(0, 32'h80);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rdr_stall_next_addr", imem_addr_v[0], 32'h80);
    cyc(0, 0, 0, 0, 0, 0);

    // Wrap-around instance, then reset mid-wait
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      push(1, RPC1 + 32'(i * 4));
      cyc(1, 0, 0, 0, 0, 1);
      chk("wrap_addr", imem_addr_v[1], RPC1 + 32'(i * 4));
    end
    cyc(1, 0, 0, 0, 0, 0);
    chk("wrap_wait_addr", imem_addr_v[1], 32'd4);
    cyc(1, 1, 0, 0, 0, 0);
    chk("midrst_req", {31'b0, imem_req_v[1]}, 0);
    chk("midrst_pc", pc_if_v[1], RPC1);
    chk("midrst_valid", {31'b0, valid_v[1]}, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("midrst_addr", imem_addr_v[1], RPC1);
    chk("midrst_req_after", {31'b0, imem_req_v[1]}, 1);

    @(negedge clk);
    #5;
    chk("sb_drain0", 32'(q0.size()), 0);
    chk("sb_drain1", 32'(q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
